// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and opcode bytes from the RX flag
// buffer, drives the ALU, captures its result and hands it to the UART TX.
// A partial frame is discarded if the next byte takes too long to arrive.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_GET_A   | idle / wait for operand A byte (never times out)
// S_GET_B   | wait for operand B byte (inter-byte timeout active)
// S_GET_OP  | wait for opcode byte (inter-byte timeout active)
// S_EXEC    | ALU sees stable operands for one cycle, result captured
// S_SEND    | one-cycle start pulse to the TX
// S_WAIT_TX | wait for the TX done pulse before the next frame
module uart_alu_ctrl #(
    parameter int W           = 8,
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx_flag,
    input  logic [W-1:0]    i_rx_data,
    output logic            o_rx_clr,
    output logic [W-1:0]    o_alu_a,
    output logic [W-1:0]    o_alu_b,
    output logic [OP_W-1:0] o_alu_op,
    input  logic [W-1:0]    i_alu_result,
    output logic            o_tx_start,
    output logic [W-1:0]    o_tx_data,
    input  logic            i_tx_done,
    output logic            o_busy,
    output logic            o_err
);

    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t state;
    state_t state_next;
    logic   timeout_hit;

    // Inter-byte timeout; a byte arriving in the expiry cycle wins over the abort.
    if (TIMEOUT_CYC > 0) begin : g_timeout
        localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

        logic [CNT_W-1:0] cnt;
        logic             in_wait;

        assign in_wait     = (state == S_GET_B) || (state == S_GET_OP);
        assign timeout_hit = in_wait && !i_rx_flag && (cnt == CNT_LAST);

        // Counter runs only while waiting for the next byte of a started frame.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                cnt <= '0;
            end else if (!in_wait || i_rx_flag || timeout_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and combinational RX clear.
    always_comb begin
        state_next = state;
        o_rx_clr   = 1'b0;
        case (state)
            S_GET_A: begin
                o_rx_clr = i_rx_flag;
                if (i_rx_flag) state_next = S_GET_B;
            end
            S_GET_B: begin
                o_rx_clr = i_rx_flag;
                if (i_rx_flag)        state_next = S_GET_OP;
                else if (timeout_hit) state_next = S_GET_A;
            end
            S_GET_OP: begin
                o_rx_clr = i_rx_flag;
                if (i_rx_flag)        state_next = S_EXEC;
                else if (timeout_hit) state_next = S_GET_A;
            end
            S_EXEC:    state_next = S_SEND;
            S_SEND:    state_next = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) state_next = S_GET_A;
            default:   state_next = S_GET_A;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        o_tx_start = (state == S_SEND);
        o_busy     = (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);
    end

    // Operand, opcode and result registers plus the error pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_err     <= 1'b0;
        end else begin
            o_err <= timeout_hit;
            if (state == S_GET_A && i_rx_flag)  o_alu_a   <= i_rx_data;
            if (state == S_GET_B && i_rx_flag)  o_alu_b   <= i_rx_data;
            if (state == S_GET_OP && i_rx_flag) o_alu_op  <= i_rx_data[OP_W-1:0];
            if (state == S_EXEC)                o_tx_data <= i_alu_result;
        end
    end

endmodule
